// File: rtl/misc_v_pkg.sv
// Shared definitions for the 16-bit MISC-V pipeline: NOP encoding,
// fetch FSM state encoding and default PC increment.
package misc_v_pkg;

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] PC_STEP_DEFAULT = 16'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {PC, instruction} park buffer used while IF/ID is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] new_pc,
  input  logic [15:0] new_ir,
  output logic [15:0] pc,
  output logic [15:0] ir
);

  // Load wins over clear; the FSM never asserts both together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= 16'h0000;
      ir <= 16'h0000;
    end else if (load) begin
      pc <= new_pc;
      ir <= new_ir;
    end else if (clear) begin
      pc <= 16'h0000;
      ir <= 16'h0000;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests instruction memory and
// feeds IF/ID, parking a returned word while the hazard unit stalls.
module fetch_unit
  import misc_v_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [15:0] IMemData,
  output logic [15:0] OPC,
  output logic [15:0] OIR,
  output logic        IRWrite,
  output logic        Flush,
  output logic [1:0]  dbg_state
);

  // Memory handshake: a word transfers on any cycle where IMemReq and
  // IMemReady are both high; IMemReq may drop without a transfer.
  fetch_state_t state, state_next;
  logic [15:0]  pc;
  logic [15:0]  buf_pc, buf_ir;
  logic         accept, park, unpark_drop;

  assign accept      = (state == FETCH) && IMemReady && !Redirect;
  assign park        = accept && Stall;
  assign unpark_drop = (state == HOLD) && Redirect;
  assign dbg_state   = state;

  fetch_hold_buf u_hold_buf (
    .clk    (CLK),
    .rst_n  (Reset),
    .load   (park),
    .clear  (unpark_drop),
    .new_pc (pc),
    .new_ir (IMemData),
    .pc     (buf_pc),
    .ir     (buf_ir)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      if (Redirect)
        pc <= RedirectPC;
      else if (accept)
        pc <= pc + PC_STEP;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = park ? HOLD : FETCH;
      HOLD:    state_next = (Redirect || !Stall) ? FETCH : HOLD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    IMemReq  = 1'b0;
    IMemAddr = pc;
    OPC      = pc;
    OIR      = NOP;
    IRWrite  = 1'b0;
    Flush    = Redirect;
    case (state)
      FETCH: begin
        IMemReq = 1'b1;
        if (accept && !Stall) begin
          IRWrite = 1'b1;
          OIR     = IMemData;
        end
      end
      HOLD: begin
        OPC     = buf_pc;
        OIR     = buf_ir;
        IRWrite = !Redirect && !Stall;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// stimulus compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall, redirect, imem_ready;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_req, ir_write, flush;
  logic [15:0] imem_addr, opc, oir;
  logic [1:0]  dbg_state;

  int checks_total;
  int checks_passed;

  // Model: whether fetching has begun, the PC, and parked {pc, ir} entries.
  bit          m_started;
  logic [15:0] m_pc;
  logic [31:0] parked_q[$];

  fetch_unit dut (
    .CLK        (clk),
    .Reset      (rst_n),
    .Stall      (stall),
    .Redirect   (redirect),
    .RedirectPC (redirect_pc),
    .IMemReq    (imem_req),
    .IMemAddr   (imem_addr),
    .IMemReady  (imem_ready),
    .IMemData   (imem_data),
    .OPC        (opc),
    .OIR        (oir),
    .IRWrite    (ir_write),
    .Flush      (flush),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp)
      checks_passed++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_pc      = 16'h0000;
    parked_q.delete();
  endtask

  task automatic compare_outputs();
    bit          parked;
    logic        e_wr;
    logic [15:0] e_opc, e_oir;
    parked = (parked_q.size() != 0);
    if (parked) e_wr = !redirect && !stall;
    else        e_wr = !redirect && m_started && imem_ready && !stall;
    e_opc = parked ? parked_q[0][31:16] : m_pc;
    e_oir = parked ? parked_q[0][15:0] : (e_wr ? imem_data : 16'h0000);
    check("imem_req",  {31'd0, imem_req}, {31'd0, m_started && !parked});
    check("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
    check("flush",     {31'd0, flush},    {31'd0, redirect});
    check("ir_write",  {31'd0, ir_write}, {31'd0, e_wr});
    check("opc",       {16'd0, opc},      {16'd0, e_opc});
    check("oir",       {16'd0, oir},      {16'd0, e_oir});
  endtask

  task automatic model_advance();
    if (!m_started) begin
      m_started = 1'b1;
      if (redirect) m_pc = redirect_pc;
    end else if (parked_q.size() != 0) begin
      if (redirect) begin
        parked_q.delete();
        m_pc = redirect_pc;
      end else if (!stall) begin
        parked_q.delete();
      end
    end else if (redirect) begin
      m_pc = redirect_pc;
    end else if (imem_ready) begin
      if (stall) parked_q.push_back({m_pc, imem_data});
      m_pc = m_pc + 16'd2;
    end
  endtask

  // One clock: drive inputs, check combinational outputs, clock, update model.
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                      input logic rdy, input logic [15:0] dat);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_data   = dat;
    #1;
    compare_outputs();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"},  {16'd0, imem_addr}, 32'h0000);
    check({tag, "_opc"},   {16'd0, opc},      32'h0000);
    check({tag, "_oir"},   {16'd0, oir},      32'h0000);
    check({tag, "_wr"},    {31'd0, ir_write}, 32'd0);
    check({tag, "_flush"}, {31'd0, flush},    32'd0);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b0;
    stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 0; imem_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Zero-wait streaming from reset.
    step(0, 0, 16'h0, 1, 16'hA000);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1, 16'hA001 + 16'(i));

    // Wait states at 0x0010.
    step(0, 1, 16'h0010, 1, 16'hDEAD);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 16'hBEEF);
    step(0, 0, 16'h0, 1, 16'h1111);
    check("addr_after_wait", {16'd0, imem_addr}, 32'h0012);

    // Stall while data returns at 0x1234, then release.
    step(0, 1, 16'h1234, 0, 16'h0);
    step(1, 0, 16'h0, 1, 16'h5678);
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 1, 16'h9999);
    check("hold_opc", {16'd0, opc}, 32'h1234);
    step(0, 0, 16'h0, 1, 16'h9999);
    check("after_hold_addr", {16'd0, imem_addr}, 32'h1236);

    // Redirect during FETCH with ready, then during HOLD.
    step(0, 1, 16'h0400, 1, 16'h7777);
    check("redir_fetch_addr", {16'd0, imem_addr}, 32'h0400);
    step(1, 0, 16'h0, 1, 16'h4444);
    step(1, 1, 16'h0400, 1, 16'h4444);
    check("redir_hold_addr", {16'd0, imem_addr}, 32'h0400);
    step(0, 0, 16'h0, 1, 16'h2222);

    // PC wrap.
    step(0, 1, 16'hFFFE, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'h3333);
    check("wrap_addr", {16'd0, imem_addr}, 32'h0000);

    // Reset asserted in HOLD.
    step(1, 0, 16'h0, 1, 16'h6666);
    stall = 0; redirect = 0; imem_ready = 0;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_in_hold");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 16'h0, 1, 16'h0101);
    step(0, 0, 16'h0, 1, 16'h0202);
    check("post_reset_first_addr", {16'd0, imem_addr}, 32'h0002);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           16'($urandom_range(0, 32767) * 2),
           $urandom_range(0, 3) != 0,
           16'($urandom_range(0, 65535)));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
